mem_arbiter: RTL and testbench

Shares the single-ported unified RAM between the instruction-fetch port and the data-memory port of the MIPS datapath. Arbitrates between the two requesters and sequences each granted access until the RAM reports completion. Each requester gets a wait/load handshake. Sits between the datapath's memory ports and the RAM model.

---
 rtl/cpu_types_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter_dstreak.sv | 37 +++
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake states, machine word, and memory arbiter FSM states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        SERVE_I = 2'b01,
        SERVE_D = 2'b10
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the arbiter's datapath-side and RAM-side signals, with one view for the
// arbiter and one for a bench driving the datapath and RAM sides.
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      CLK;
    logic      nRST;
    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    modport arb (
        input  CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

    modport tb (
        output CLK, nRST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/mem_arbiter_dstreak.sv
// Saturating count of consecutive data grants taken while an instruction fetch waits.
// Only compiled when ARB_FAIR_EN is defined.
`ifdef ARB_FAIR_EN
module dstreak_counter #(
    parameter int MAX_DSTREAK = 4
) (
    input  logic CLK,
    input  logic nRST,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_max_o
);
    localparam int W = $clog2(MAX_DSTREAK + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_max_o = (cnt_q == W'(MAX_DSTREAK));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/mem_arbiter.sv
// Arbitrates the unified RAM between instruction fetch and data ports (data first).
// Define ARB_FAIR_EN to force an instruction grant after MAX_DSTREAK data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int MAX_DSTREAK = 4
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      iREN,
    input  word_t     iaddr,
    output logic      iwait,
    output word_t     iload,
    input  logic      dREN,
    input  logic      dWEN,
    input  word_t     daddr,
    input  word_t     dstore,
    output logic      dwait,
    output word_t     dload,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    if (MAX_DSTREAK < 1) begin : g_bad_param
        $error("MAX_DSTREAK must be at least 1");
    end

    arb_state_t state_q, state_d;
    logic       ren_q, ren_d, wen_q, wen_d;
    word_t      addr_q, addr_d, store_q, store_d;
    logic       d_req, i_done, d_done, force_i;

    assign d_req  = dREN | dWEN;
    // A withdrawn request never completes, even if the RAM says ACCESS that cycle.
    assign i_done = (state_q == SERVE_I) && (ramstate == ACCESS) && iREN;
    assign d_done = (state_q == SERVE_D) && (ramstate == ACCESS) && d_req;

`ifdef ARB_FAIR_EN
    logic at_max;

    dstreak_counter #(.MAX_DSTREAK(MAX_DSTREAK)) u_dstreak (
        .CLK      (CLK),
        .nRST     (nRST),
        .inc_i    (d_done && iREN),
        .clr_i    (i_done || !iREN),
        .at_max_o (at_max)
    );

    assign force_i = at_max && iREN;
`else
    assign force_i = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (d_req && !force_i) state_d = SERVE_D;
                else if (iREN)         state_d = SERVE_I;
            end
            SERVE_I: if (!iREN || i_done) state_d = IDLE;
            SERVE_D: if (!d_req || d_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are registered against the state being entered, so they
    // appear the cycle after arbitration and drop the cycle after completion.
    always_comb begin
        ren_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = '0;
        store_d = '0;
        case (state_d)
            SERVE_I: begin
                ren_d  = 1'b1;
                addr_d = iaddr;
            end
            SERVE_D: begin
                ren_d   = dREN & ~dWEN;
                wen_d   = dWEN;
                addr_d  = daddr;
                store_d = dstore;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
        end else begin
            state_q <= state_d;
            ren_q   <= ren_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            store_q <= store_d;
        end
    end

    assign ramREN   = ren_q;
    assign ramWEN   = wen_q;
    assign ramaddr  = addr_q;
    assign ramstore = store_q;
    assign iwait    = ~i_done;
    assign dwait    = ~d_done;
    assign iload    = ramload;
    assign dload    = ramload;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset and streak sequences.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    mem_arbiter_if bus ();

    mem_arbiter #(.MAX_DSTREAK(4)) dut (
        .CLK      (bus.CLK),
        .nRST     (bus.nRST),
        .iREN     (bus.iREN),
        .iaddr    (bus.iaddr),
        .iwait    (bus.iwait),
        .iload    (bus.iload),
        .dREN     (bus.dREN),
        .dWEN     (bus.dWEN),
        .daddr    (bus.daddr),
        .dstore   (bus.dstore),
        .dwait    (bus.dwait),
        .dload    (bus.dload),
        .ramREN   (bus.ramREN),
        .ramWEN   (bus.ramWEN),
        .ramaddr  (bus.ramaddr),
        .ramstore (bus.ramstore),
        .ramload  (bus.ramload),
        .ramstate (bus.ramstate)
    );

    initial bus.CLK = 1'b0;
    always #5 bus.CLK = ~bus.CLK;

    typedef struct {
        logic      iren;
        word_t     iaddr;
        logic      dren;
        logic      dwen;
        word_t     daddr;
        word_t     dstore;
        ramstate_t rs;
        word_t     rload;
        logic      e_iwait;
        logic      e_dwait;
        logic      e_ren;
        logic      e_wen;
        word_t     e_addr;
        word_t     e_store;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic add(input logic iren, input word_t iaddr, input logic dren, input logic dwen,
                       input word_t daddr, input word_t dstore, input ramstate_t rs, input word_t rload,
                       input logic eiw, input logic edw, input logic eren, input logic ewen,
                       input word_t eaddr, input word_t estore);
        vec_t v;
        v.iren = iren; v.iaddr = iaddr; v.dren = dren; v.dwen = dwen;
        v.daddr = daddr; v.dstore = dstore; v.rs = rs; v.rload = rload;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_ren = eren; v.e_wen = ewen;
        v.e_addr = eaddr; v.e_store = estore;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic iren, input word_t iaddr, input logic dren, input logic dwen,
                         input word_t daddr, input word_t dstore, input ramstate_t rs, input word_t rload);
        bus.iREN = iren; bus.iaddr = iaddr; bus.dREN = dren; bus.dWEN = dwen;
        bus.daddr = daddr; bus.dstore = dstore; bus.ramstate = rs; bus.ramload = rload;
    endtask

    task automatic chk_bus(input string tag, input logic eiw, input logic edw, input logic eren,
                           input logic ewen, input word_t eaddr, input word_t estore);
        chk({tag, ".iwait"},    32'(bus.iwait),  32'(eiw));
        chk({tag, ".dwait"},    32'(bus.dwait),  32'(edw));
        chk({tag, ".ramREN"},   32'(bus.ramREN), 32'(eren));
        chk({tag, ".ramWEN"},   32'(bus.ramWEN), 32'(ewen));
        chk({tag, ".ramaddr"},  bus.ramaddr,     eaddr);
        chk({tag, ".ramstore"}, bus.ramstore,    estore);
    endtask

    initial begin
        int g;
        int i_low;
        logic is_i;

        // Instruction-only read, two-cycle latency, then the idle bubble.
        add(0, 0,     0, 0, 0, 0, FREE, 0,                   1, 1, 0, 0, 0, 0);
        add(1, 'h40,  0, 0, 0, 0, FREE, 0,                   1, 1, 0, 0, 0, 0);
        add(1, 'h40,  0, 0, 0, 0, ACCESS, 32'h8C220004,      0, 1, 1, 0, 'h40, 0);
        add(0, 0,     0, 0, 0, 0, FREE, 0,                   1, 1, 0, 0, 0, 0);
        // Write and fetch together: data first, fetch after the bubble.
        add(1, 'h44,  0, 1, 'h100, 32'hDEADBEEF, FREE, 0,    1, 1, 0, 0, 0, 0);
        add(1, 'h44,  0, 1, 'h100, 32'hDEADBEEF, ACCESS, 32'h11111111, 1, 0, 0, 1, 'h100, 32'hDEADBEEF);
        add(1, 'h44,  0, 0, 0, 0, FREE, 0,                   1, 1, 0, 0, 0, 0);
        add(1, 'h44,  0, 0, 0, 0, ACCESS, 32'h22222222,      0, 1, 1, 0, 'h44, 0);
        add(0, 0,     0, 0, 0, 0, FREE, 0,                   1, 1, 0, 0, 0, 0);
        // Read held through BUSY x3 and ERROR before ACCESS.
        add(0, 0, 1, 0, 'h200, 32'hAAAA5555, FREE, 0,        1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 'h200, 32'hAAAA5555, BUSY, 0,        1, 1, 1, 0, 'h200, 32'hAAAA5555);
        add(0, 0, 1, 0, 'h200, 32'hAAAA5555, BUSY, 0,        1, 1, 1, 0, 'h200, 32'hAAAA5555);
        add(0, 0, 1, 0, 'h200, 32'hAAAA5555, BUSY, 0,        1, 1, 1, 0, 'h200, 32'hAAAA5555);
        add(0, 0, 1, 0, 'h200, 32'hAAAA5555, ERROR, 0,       1, 1, 1, 0, 'h200, 32'hAAAA5555);
        add(0, 0, 1, 0, 'h200, 32'hAAAA5555, ACCESS, 32'h33333333, 1, 0, 1, 0, 'h200, 32'hAAAA5555);
        add(0, 0, 0, 0, 0, 0, FREE, 0,                       1, 1, 0, 0, 0, 0);
        // Withdrawal during BUSY: back to idle, no completion even on ACCESS.
        add(0, 0, 1, 0, 'h300, 0, FREE, 0,                   1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 'h300, 0, BUSY, 0,                   1, 1, 1, 0, 'h300, 0);
        add(0, 0, 0, 0, 'h300, 0, BUSY, 0,                   1, 1, 1, 0, 'h300, 0);
        add(0, 0, 0, 0, 0, 0, ACCESS, 0,                     1, 1, 0, 0, 0, 0);
        // dREN and dWEN together: write wins.
        add(0, 0, 1, 1, 'h400, 32'h12345678, FREE, 0,        1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 'h400, 32'h12345678, ACCESS, 0,      1, 0, 0, 1, 'h400, 32'h12345678);
        add(0, 0, 0, 0, 0, 0, FREE, 0,                       1, 1, 0, 0, 0, 0);

        bus.nRST = 1'b0;
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        #12;
        chk_bus("reset", 1, 1, 0, 0, 0, 0);
        @(negedge bus.CLK);
        bus.nRST = 1'b1;

        foreach (vecs[k]) begin
            @(posedge bus.CLK);
            #1;
            drive(vecs[k].iren, vecs[k].iaddr, vecs[k].dren, vecs[k].dwen,
                  vecs[k].daddr, vecs[k].dstore, vecs[k].rs, vecs[k].rload);
            #1;
            chk_bus($sformatf("vec%0d", k), vecs[k].e_iwait, vecs[k].e_dwait, vecs[k].e_ren,
                    vecs[k].e_wen, vecs[k].e_addr, vecs[k].e_store);
            chk($sformatf("vec%0d.iload", k), bus.iload, vecs[k].rload);
            chk($sformatf("vec%0d.dload", k), bus.dload, vecs[k].rload);
        end

        // Reset asserted in the middle of a data read.
        @(posedge bus.CLK);
        #1;
        drive(0, 0, 1, 0, 'h500, 0, BUSY, 0);
        @(posedge bus.CLK);
        #2;
        chk("pre_rst.ramREN", 32'(bus.ramREN), 32'd1);
        chk("pre_rst.ramaddr", bus.ramaddr, 32'h500);
        #1;
        bus.nRST = 1'b0;
        #1;
        chk_bus("mid_rst", 1, 1, 0, 0, 0, 0);
        bus.ramstate = ACCESS;
        #1;
        chk("mid_rst.dwait_on_access", 32'(bus.dwait), 32'd1);
        @(negedge bus.CLK);
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        bus.nRST = 1'b1;
        @(posedge bus.CLK);
        #2;
        chk_bus("post_rst", 1, 1, 0, 0, 0, 0);

        // Continuous fetch and data read with the RAM always answering ACCESS.
        @(posedge bus.CLK);
        #1;
        drive(1, 'h80, 1, 0, 'h600, 0, ACCESS, 0);
        g = 0;
        i_low = 0;
        for (int c = 0; c < 40 && g < 10; c++) begin
            @(posedge bus.CLK);
            #2;
            if (!bus.iwait) i_low++;
            if (bus.ramREN) begin
                is_i = (bus.ramaddr == 32'h80);
                chk($sformatf("grant%0d.addr_valid", g),
                    32'(bus.ramaddr == 32'h80 || bus.ramaddr == 32'h600), 32'd1);
                chk($sformatf("grant%0d.is_instr", g), 32'(is_i), 32'(FAIR && (g % 5 == 4)));
                g++;
            end
        end
        chk("grant_count", 32'(g), 32'd10);
        chk("instr_completions", 32'(i_low), FAIR ? 32'd2 : 32'd0);
        drive(0, 0, 0, 0, 0, 0, FREE, 0);
        repeat (2) @(posedge bus.CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
